// File: rtl/pt_check_pkg.sv
// Shared types and default constants for the plaintext checker.
package pt_check_pkg;

  localparam logic [7:0] PT_LO_DEFAULT = 8'h20;
  localparam logic [7:0] PT_HI_DEFAULT = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } pt_state_e;

endpackage

// File: rtl/pt_byte_check.sv
// Combinational test of one decrypted byte against the printable range [lo, hi].
module pt_byte_check (
  input  logic [7:0] in_data,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  output logic       ok
);

  assign ok = (in_data >= lo) && (in_data <= hi);

endmodule

// File: rtl/pt_check.sv
// Checks that a decrypted message is all printable bytes and reports a verdict per key.
// Define PT_CHECK_COMMIT_EN to also write accepted plaintext bytes out to memory.
module pt_check
  import pt_check_pkg::*;
#(
  parameter logic [7:0] LO = PT_LO_DEFAULT,
  parameter logic [7:0] HI = PT_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  msg_len,
  input  logic [23:0] key_in,
  input  logic        in_valid,
  input  logic [7:0]  in_addr,
  input  logic [7:0]  in_data,
  output logic        rdy,
  output logic        done,
  output logic        found,
  output logic [23:0] key_out,
  output logic        pt_wren,
  output logic [7:0]  pt_addr,
  output logic [7:0]  pt_wrdata
);

  pt_state_e  state;
  logic [7:0] len_q;
  logic [7:0] exp_idx;
  logic       byte_ok;
  logic       byte_take;
  logic       accept;

  pt_byte_check u_byte_check (
    .in_data (in_data),
    .lo      (LO),
    .hi      (HI),
    .ok      (byte_ok)
  );

  // start always wins, so a strobe arriving with it never counts as a byte
  assign byte_take = (state == ST_CHECK) && in_valid && !start;
  assign accept    = byte_take && byte_ok && (in_addr == exp_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rdy     <= 1'b1;
      done    <= 1'b0;
      found   <= 1'b0;
      key_out <= '0;
      len_q   <= '0;
      exp_idx <= '0;
    end else if (start) begin
      len_q   <= msg_len;
      key_out <= key_in;
      exp_idx <= 8'd1;
      if (msg_len == 8'd0) begin
        state <= ST_PASS;
        rdy   <= 1'b1;
        done  <= 1'b1;
        found <= 1'b1;
      end else begin
        state <= ST_CHECK;
        rdy   <= 1'b0;
        done  <= 1'b0;
        found <= 1'b0;
      end
    end else if (byte_take) begin
      if (!accept) begin
        state <= ST_FAIL;
        rdy   <= 1'b1;
        done  <= 1'b1;
        found <= 1'b0;
      end else if (in_addr == len_q) begin
        state <= ST_PASS;
        rdy   <= 1'b1;
        done  <= 1'b1;
        found <= 1'b1;
      end else begin
        exp_idx <= exp_idx + 8'd1;
      end
    end
  end

`ifdef PT_CHECK_COMMIT_EN
  // Address 0 holds the length, mirroring the ciphertext layout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_wren   <= 1'b0;
      pt_addr   <= '0;
      pt_wrdata <= '0;
    end else begin
      pt_wren <= 1'b0;
      if (start) begin
        pt_wren   <= 1'b1;
        pt_addr   <= 8'd0;
        pt_wrdata <= msg_len;
      end else if (accept) begin
        pt_wren   <= 1'b1;
        pt_addr   <= in_addr;
        pt_wrdata <= in_data;
      end
    end
  end
`else
  assign pt_wren   = 1'b0;
  assign pt_addr   = 8'd0;
  assign pt_wrdata = 8'd0;
`endif

endmodule

// File: tb/tb_pt_check.sv
// Randomized self-checking bench for pt_check against a message-level reference model.
module tb_pt_check;

  localparam logic [7:0] LO = 8'h20;
  localparam logic [7:0] HI = 8'h7E;

  localparam int PH_IDLE  = 0;
  localparam int PH_CHECK = 1;
  localparam int PH_PASS  = 2;
  localparam int PH_FAIL  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  msg_len;
  logic [23:0] key_in;
  logic        in_valid;
  logic [7:0]  in_addr;
  logic [7:0]  in_data;
  logic        rdy;
  logic        done;
  logic        found;
  logic [23:0] key_out;
  logic        pt_wren;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_wrdata;

  int vectors = 0;
  int miscompares = 0;

  // reference model: what has been received of the current candidate message
  int          m_phase;
  logic [7:0]  m_len;
  logic [7:0]  m_next;
  logic [23:0] m_key;
  logic        m_wren;
  logic [7:0]  m_waddr;
  logic [7:0]  m_wdata;

  always #5 clk = ~clk;

  pt_check dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .msg_len   (msg_len),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .rdy       (rdy),
    .done      (done),
    .found     (found),
    .key_out   (key_out),
    .pt_wren   (pt_wren),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_phase = PH_IDLE;
    m_len   = 8'd0;
    m_next  = 8'd1;
    m_key   = 24'd0;
    m_wren  = 1'b0;
    m_waddr = 8'd0;
    m_wdata = 8'd0;
  endtask

  task automatic modelStep(input logic st, input logic [7:0] len, input logic [23:0] key,
                           input logic v, input logic [7:0] a, input logic [7:0] d);
    m_wren = 1'b0;
    if (st) begin
      m_len   = len;
      m_key   = key;
      m_next  = 8'd1;
      m_phase = (len == 0) ? PH_PASS : PH_CHECK;
      m_wren  = 1'b1;
      m_waddr = 8'd0;
      m_wdata = len;
    end else if (m_phase == PH_CHECK && v) begin
      if (d < LO || d > HI || a != m_next) begin
        m_phase = PH_FAIL;
      end else begin
        m_wren  = 1'b1;
        m_waddr = a;
        m_wdata = d;
        if (a == m_len) m_phase = PH_PASS;
        else m_next = m_next + 8'd1;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".rdy"},   32'(rdy),   32'(m_phase != PH_CHECK));
    checkOutput({tag, ".done"},  32'(done),  32'(m_phase == PH_PASS || m_phase == PH_FAIL));
    checkOutput({tag, ".found"}, 32'(found), 32'(m_phase == PH_PASS));
    checkOutput({tag, ".key"},   32'(key_out), 32'(m_key));
`ifdef PT_CHECK_COMMIT_EN
    checkOutput({tag, ".pt_wren"}, 32'(pt_wren), 32'(m_wren));
    if (m_wren) begin
      checkOutput({tag, ".pt_addr"},   32'(pt_addr),   32'(m_waddr));
      checkOutput({tag, ".pt_wrdata"}, 32'(pt_wrdata), 32'(m_wdata));
    end
`else
    checkOutput({tag, ".pt_bus"}, {15'd0, pt_wren, pt_addr, pt_wrdata}, 32'd0);
`endif
  endtask

  task automatic applyStimulus(input string tag, input logic st, input logic [7:0] len,
                               input logic [23:0] key, input logic v,
                               input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    start    = st;
    msg_len  = len;
    key_in   = key;
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    modelStep(st, len, key, v, a, d);
    @(posedge clk);
    #1;
    compareAll(tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(tag, 1'b0, 8'd0, 24'd0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic sendByte(input string tag, input logic [7:0] a, input logic [7:0] d);
    applyStimulus(tag, 1'b0, 8'd0, 24'd0, 1'b1, a, d);
  endtask

  // asserted away from the clock edge so the asynchronous path is what gets observed
  task automatic pulseReset(input string tag);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    compareAll(tag);
    checkOutput({tag, ".rdy_now"}, 32'(rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] badByte();
    logic [7:0] b;
    if ($urandom_range(0, 1) == 0) b = 8'($urandom_range(0, 31));
    else b = 8'($urandom_range(127, 255));
    return b;
  endfunction

  initial begin
    logic [7:0]  len;
    logic [7:0]  a;
    logic [7:0]  d;
    logic [23:0] key;
    int          r;
    int          guard;

    rst_n = 1'b0; start = 1'b0; msg_len = '0; key_in = '0;
    in_valid = 1'b0; in_addr = '0; in_data = '0;
    modelReset();
    #12;
    compareAll("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle("idle");
    sendByte("idle_valid", 8'd1, 8'h41);

    applyStimulus("hi_start", 1'b1, 8'd3, 24'h000018, 1'b0, 8'd0, 8'd0);
    sendByte("hi_b1", 8'd1, "H");
    idleCycle("hi_gap");
    sendByte("hi_b2", 8'd2, "i");
    sendByte("hi_b3", 8'd3, "!");
    checkOutput("hi_found", 32'(found), 32'd1);
    checkOutput("hi_key", 32'(key_out), 32'h000018);
    sendByte("pass_ignore", 8'd4, 8'h00);

    applyStimulus("bad_start", 1'b1, 8'd4, 24'hABCDEF, 1'b0, 8'd0, 8'd0);
    sendByte("bad_b1", 8'd1, "a");
    sendByte("bad_b2", 8'd2, 8'h7F);
    checkOutput("bad_done", 32'({done, found}), 32'b10);
    sendByte("bad_b3", 8'd3, "b");

    applyStimulus("zero_start", 1'b1, 8'd0, 24'h123456, 1'b1, 8'd1, "x");
    checkOutput("zero_done", 32'({done, found}), 32'b11);

    applyStimulus("skip_start", 1'b1, 8'd5, 24'h00FF00, 1'b0, 8'd0, 8'd0);
    sendByte("skip_b1", 8'd1, "q");
    sendByte("skip_b3", 8'd3, "r");
    checkOutput("skip_fail", 32'({done, found}), 32'b10);

    applyStimulus("rs_start1", 1'b1, 8'd5, 24'h111111, 1'b0, 8'd0, 8'd0);
    sendByte("rs_b1", 8'd1, "A");
    sendByte("rs_b2", 8'd2, "B");
    applyStimulus("rs_start2", 1'b1, 8'd2, 24'h222222, 1'b1, 8'd3, "C");
    sendByte("rs2_b1", 8'd1, "o");
    sendByte("rs2_b2", 8'd2, "k");
    checkOutput("rs_key", 32'(key_out), 32'h222222);
    applyStimulus("mid_start", 1'b1, 8'd6, 24'h333333, 1'b0, 8'd0, 8'd0);
    sendByte("mid_b1", 8'd1, "z");
    pulseReset("mid_reset");
    idleCycle("post_reset");

    for (int c = 0; c < 60; c++) begin
      len = 8'($urandom_range(0, 10));
      key = 24'($urandom);
      applyStimulus("rnd_start", 1'b1, len, key, 1'($urandom_range(0, 1)), 8'd1, "s");
      guard = 0;
      while (m_phase == PH_CHECK && guard < 40) begin
        guard++;
        r = $urandom_range(0, 99);
        if (r < 4) begin
          applyStimulus("rnd_restart", 1'b1, 8'($urandom_range(1, 8)), 24'($urandom),
                        1'b0, 8'd0, 8'd0);
        end else if (r < 20) begin
          idleCycle("rnd_idle");
        end else begin
          a = m_next;
          d = 8'($urandom_range(32, 126));
          if (r < 25) d = badByte();
          else if (r < 29) a = m_next + 8'($urandom_range(1, 5));
          sendByte("rnd_byte", a, d);
        end
      end
      if (c == 30 && m_phase == PH_CHECK) pulseReset("rnd_reset");
      repeat ($urandom_range(0, 2))
        sendByte("rnd_after", 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
